// File: rtl/dd_xfer_pkg.sv
// Shared types for the dd_xfer_arb channel arbiter: FSM state encoding
// and the requester-index width helper.
package dd_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } dd_xfer_state_t;

  function automatic int dd_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dd_sync.sv
// Multi-flop synchronizer for signals arriving from another clock domain.
module dd_sync #(
  parameter int                 WIDTH   = 1,
  parameter int                 STAGES  = 2,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift chain; first stage may go metastable, later stages settle it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dd_xfer_arb.sv
// Round-robin arbiter sharing one 4-phase req/ack CDC channel between
// N_REQ source-domain requesters; data is held for the full handshake.
module dd_xfer_arb
  import dd_xfer_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic                   xfer_req_o,
  output logic [WIDTH-1:0]       xfer_data_o,
  input  logic                   xfer_ack_i
);

  localparam int IW = dd_idx_w(N_REQ);

  dd_xfer_state_t   state_q, state_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic             ack_s;
  logic [N_REQ-1:0] elig_s;
  logic [IW-1:0]    pick_s;

  dd_sync #(
    .WIDTH   (1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (xfer_ack_i),
    .q_o   (ack_s)
  );

  // First set bit at or above ptr, wrapping; scanning downward lets the
  // smallest offset win.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] elig,
                                            input logic [IW-1:0]    ptr);
    logic [IW-1:0] pick;
    int            idx;
    pick = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (elig[idx]) begin
        pick = IW'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // The requester finishing this cycle is masked so it cannot re-win.
  assign elig_s = req_i & ~done_q;
  assign pick_s = rr_pick(elig_s, rr_q);

  // Next-state and registered-output logic for the handshake sequencer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = {N_REQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        // A stale ack left over from a reset must drain before a new request.
        if ((|elig_s) && !ack_s) begin
          sel_d   = pick_s;
          data_d  = data_i[int'(pick_s)*WIDTH +: WIDTH];
          req_d   = 1'b1;
          state_d = ST_ASSERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_ASSERT;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          done_d[sel_q] = 1'b1;
          rr_d          = (sel_q == IW'(N_REQ - 1)) ? {IW{1'b0}} : sel_q + IW'(1);
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= {IW{1'b0}};
      rr_q    <= {IW{1'b0}};
      req_q   <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
      done_q  <= {N_REQ{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign xfer_req_o  = req_q;
  assign xfer_data_o = data_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dd_xfer_arb.sv
// Directed bench for dd_xfer_arb with a negedge destination-side ack model.
module tb_dd_xfer_arb;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_REQ-1:0]       req_i = '0;
  logic [N_REQ*WIDTH-1:0] data_i = '0;
  logic [N_REQ-1:0]       done_o;
  logic                   busy_o;
  logic                   xfer_req_o;
  logic [WIDTH-1:0]       xfer_data_o;
  logic                   xfer_ack_i;

  logic model_en  = 1'b1;
  logic model_ack = 1'b0;
  logic man_ack   = 1'b0;
  int   ack_dly   = 3;
  int   rel_dly   = 3;
  int   mcnt      = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;

  assign xfer_ack_i = model_en ? model_ack : man_ack;

  always #5 clk = ~clk;

  dd_xfer_arb #(
    .N_REQ       (N_REQ),
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .data_i      (data_i),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .xfer_req_o  (xfer_req_o),
    .xfer_data_o (xfer_data_o),
    .xfer_ack_i  (xfer_ack_i)
  );

  // Destination model: ack follows req after ack_dly / rel_dly negedges.
  always @(negedge clk) begin
    if (!model_en) begin
      model_ack = 1'b0;
      mcnt      = 0;
    end else if (xfer_req_o != model_ack) begin
      mcnt = mcnt + 1;
      if (mcnt >= (xfer_req_o ? ack_dly : rel_dly)) begin
        model_ack = xfer_req_o;
        mcnt      = 0;
      end
    end else begin
      mcnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget, input logic [N_REQ-1:0] exp, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (done_o == '0 && n < budget);
    chk(tag, 32'(done_o), 32'(exp));
  endtask

  initial begin
    // Reset values while rst_n is low.
    #12;
    chk("rst_req",  32'(xfer_req_o), 32'd0);
    chk("rst_data", xfer_data_o,     32'd0);
    chk("rst_done", 32'(done_o),     32'd0);
    chk("rst_busy", 32'(busy_o),     32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();

    // Single transfer from requester 2.
    data_i[2*WIDTH +: WIDTH] = 32'hCAFE_0002;
    req_i = 4'b0100;
    step();
    chk("single_req",  32'(xfer_req_o), 32'd1);
    chk("single_data", xfer_data_o,     32'hCAFE_0002);
    chk("single_busy", 32'(busy_o),     32'd1);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("single_hold", xfer_data_o,     32'hCAFE_0002);
      chk("single_reqk", 32'(xfer_req_o), 32'(k < 5));
      chk("single_done", 32'(done_o),     (k == 10) ? 32'h4 : 32'h0);
      chk("single_bsy",  32'(busy_o),     32'(k < 10));
      if (k == 10) req_i = 4'b0000;
    end
    step();
    chk("single_once", 32'(done_o), 32'd0);
    chk("single_idle", 32'(busy_o), 32'd0);

    // Slow ack: requester 3, destination waits 50 cycles.
    ack_dly = 50;
    data_i[3*WIDTH +: WIDTH] = 32'hDEAD_0003;
    req_i = 4'b1000;
    step();
    chk("slow_req",  32'(xfer_req_o), 32'd1);
    chk("slow_data", xfer_data_o,     32'hDEAD_0003);
    for (int k = 1; k <= 57; k++) begin
      step();
      chk("slow_hold", xfer_data_o,     32'hDEAD_0003);
      chk("slow_reqk", 32'(xfer_req_o), 32'(k <= 51));
      chk("slow_done", 32'(done_o),     (k == 57) ? 32'h8 : 32'h0);
      if (k == 57) req_i = 4'b0000;
    end
    step();
    chk("slow_once", 32'(done_o), 32'd0);
    ack_dly = 3;

    // Round-robin fairness with all four requesting.
    for (int k = 0; k < N_REQ; k++) data_i[k*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(k);
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int w;
      w = i % 4;
      step();
      chk("rr_req",  32'(xfer_req_o), 32'd1);
      chk("rr_data", xfer_data_o,     32'hA000_0000 + 32'(w));
      wait_done(20, 4'(1 << w), "rr_done");
      if (i == 4) req_i = 4'b0000;
    end
    step();
    chk("rr_end_req",  32'(xfer_req_o), 32'd0);
    chk("rr_end_busy", 32'(busy_o),     32'd0);

    // Done masking: requester 1 keeps req high during its done cycle.
    data_i[1*WIDTH +: WIDTH] = 32'hB000_0001;
    req_i = 4'b0010;
    step();
    chk("mask_data", xfer_data_o, 32'hB000_0001);
    wait_done(20, 4'b0010, "mask_done");
    step();
    chk("mask_nogrant", 32'(xfer_req_o), 32'd0);
    chk("mask_busy",    32'(busy_o),     32'd0);
    req_i = 4'b0000;
    step();
    chk("mask_still", 32'(xfer_req_o), 32'd0);

    // Simultaneous: req 3 rises during requester 0's done pulse (rr_ptr -> 1).
    data_i[0*WIDTH +: WIDTH] = 32'hC000_0000;
    req_i = 4'b0001;
    step();
    chk("sim_data0", xfer_data_o, 32'hC000_0000);
    wait_done(20, 4'b0001, "sim_done0");
    data_i[3*WIDTH +: WIDTH] = 32'hD000_0003;
    req_i = 4'b1001;
    step();
    chk("sim_req3",  32'(xfer_req_o), 32'd1);
    chk("sim_data3", xfer_data_o,     32'hD000_0003);
    req_i = 4'b1000;
    wait_done(20, 4'b1000, "sim_done3");
    req_i = 4'b0000;
    step();
    step();

    // Reset mid-ASSERT with ack high.
    model_en = 1'b0;
    man_ack  = 1'b0;
    req_i    = 4'b0001;
    step();
    chk("mrst_req", 32'(xfer_req_o), 32'd1);
    man_ack = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_req0",  32'(xfer_req_o), 32'd0);
    chk("mrst_data0", xfer_data_o,     32'd0);
    chk("mrst_done0", 32'(done_o),     32'd0);
    chk("mrst_busy0", 32'(busy_o),     32'd0);
    req_i = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    req_i = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mrst_hold", 32'(xfer_req_o), 32'd0);
    end
    man_ack = 1'b0;
    step();
    chk("mrst_wait1", 32'(xfer_req_o), 32'd0);
    step();
    chk("mrst_wait2", 32'(xfer_req_o), 32'd0);
    step();
    chk("mrst_grant", 32'(xfer_req_o), 32'd1);
    chk("mrst_gdata", xfer_data_o,     32'hC000_0000);
    model_en = 1'b1;
    wait_done(30, 4'b0001, "mrst_done");
    req_i = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
